alu_share_arb: RTL

Two-requester arbiter and sequencer for the shared N-bit ALU (add/sub/and/or, zero flag). It lets the main execute path and a secondary unit, such as the branch/address calculator, time-share one ALU instance. Accepted operations are pipelined through a registered operand stage and a registered result stage. Results are returned on a single response channel tagged with the requester ID.

---
 rtl/alu_share_arb_if.sv | 31 +++
 rtl/alu_share_arb.sv | 102 ++++++++++
 2 files changed

// File: rtl/alu_share_arb_if.sv
// Bundled request, ALU-drive and response signals for the shared-ALU arbiter.
// The slave modport is the arbiter; master is the requester/ALU/consumer side.
interface alu_share_arb_if #(
    parameter int unsigned N = 32
);
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [7:0]     req_sel;
    logic [2*N-1:0] req_a;
    logic [2*N-1:0] req_b;
    logic [3:0]     alu_sel;
    logic [N-1:0]   alu_a;
    logic [N-1:0]   alu_b;
    logic [N-1:0]   alu_out;
    logic           alu_zero;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_id;
    logic [N-1:0]   rsp_data;
    logic           rsp_zero;

    modport slave (
        input  req_valid, req_sel, req_a, req_b, alu_out, alu_zero, rsp_ready,
        output req_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_zero
    );

    modport master (
        output req_valid, req_sel, req_a, req_b, alu_out, alu_zero, rsp_ready,
        input  req_ready, alu_sel, alu_a, alu_b, rsp_valid, rsp_id, rsp_data, rsp_zero
    );
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin arbiter letting two requesters time-share one combinational ALU through
// a registered operand stage (OP) and a registered, ID-tagged response stage (RSP).
module alu_share_arb #(
    parameter int unsigned N = 32
) (
    input logic            clk,
    input logic            rst_n,
    alu_share_arb_if.slave bus
);
    logic         r_op_valid;
    logic         r_op_id;
    logic [3:0]   r_op_sel;
    logic [N-1:0] r_op_a;
    logic [N-1:0] r_op_b;
    logic         r_rsp_valid;
    logic         r_rsp_id;
    logic [N-1:0] r_rsp_data;
    logic         r_rsp_zero;
    logic         r_prio;

    logic         w_rsp_free;
    logic         w_op_move;
    logic         w_op_free;
    logic [1:0]   w_grant;
    logic         w_accept;
    logic         w_acc_id;
    logic [3:0]   w_acc_sel;
    logic [N-1:0] w_acc_a;
    logic [N-1:0] w_acc_b;

    assign w_rsp_free = !r_rsp_valid || bus.rsp_ready;
    assign w_op_move  = r_op_valid && w_rsp_free;
    assign w_op_free  = !r_op_valid || w_op_move;

    always_comb begin
        w_grant = bus.req_valid;
        if (&bus.req_valid) begin
            w_grant = r_prio ? 2'b10 : 2'b01;
        end
    end

    // Gated by rst_n so nothing can be offered as accepted while reset is held.
    assign bus.req_ready = (rst_n && w_op_free) ? w_grant : 2'b00;
    assign w_accept      = |bus.req_ready;
    assign w_acc_id      = bus.req_ready[1];
    assign w_acc_sel     = w_acc_id ? bus.req_sel[7:4] : bus.req_sel[3:0];
    assign w_acc_a       = w_acc_id ? bus.req_a[2*N-1:N] : bus.req_a[N-1:0];
    assign w_acc_b       = w_acc_id ? bus.req_b[2*N-1:N] : bus.req_b[N-1:0];

    // An idle OP stage presents the "zero" opcode so stale operands never reach the ALU.
    always_comb begin
        bus.alu_sel = 4'b1111;
        bus.alu_a   = '0;
        bus.alu_b   = '0;
        if (r_op_valid) begin
            bus.alu_sel = r_op_sel;
            bus.alu_a   = r_op_a;
            bus.alu_b   = r_op_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_valid <= 1'b0;
            r_op_id    <= 1'b0;
            r_op_sel   <= 4'b0000;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_prio     <= 1'b0;
        end else if (w_accept) begin
            r_op_valid <= 1'b1;
            r_op_id    <= w_acc_id;
            r_op_sel   <= w_acc_sel;
            r_op_a     <= w_acc_a;
            r_op_b     <= w_acc_b;
            r_prio     <= ~w_acc_id;
        end else if (w_op_move) begin
            r_op_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_zero  <= 1'b0;
        end else if (w_op_move) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_op_id;
            r_rsp_data  <= bus.alu_out;
            r_rsp_zero  <= bus.alu_zero;
        end else if (r_rsp_valid && bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_zero  = r_rsp_zero;
endmodule
